// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU command codes, flag bit positions and entry sizing
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_NAND = 3'd5;
    localparam logic [2:0] ALU_NOR  = 3'd6;
    localparam logic [2:0] ALU_OR   = 3'd7;

    localparam int FLAG_OVF   = 3;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_NEG   = 0;

    // result + flags + command + tag
    function automatic int entry_w(input int tag_w);
        return 32 + 4 + 3 + tag_w;
    endfunction

    localparam int DEFAULT_TAG_W = 4;
    localparam int ENTRY_W       = entry_w(DEFAULT_TAG_W);

endpackage

// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - producer and consumer handshake signals of the writeback stage
interface alu_result_stage_if #(
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_result;
    logic             in_carryout;
    logic             in_zero;
    logic             in_overflow;
    logic [2:0]       in_command;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [3:0]       out_flags;
    logic [2:0]       out_command;
    logic [TAG_W-1:0] out_tag;

    // the stage itself
    modport slave (
        input  in_valid, in_result, in_carryout, in_zero, in_overflow, in_command, in_tag,
        output in_ready,
        output out_valid, out_result, out_flags, out_command, out_tag,
        input  out_ready
    );

    // the environment around the stage (ALU side and consumer side)
    modport master (
        output in_valid, in_result, in_carryout, in_zero, in_overflow, in_command, in_tag,
        input  in_ready,
        input  out_valid, out_result, out_flags, out_command, out_tag,
        output out_ready
    );
endinterface

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - DEPTH-entry storage with registered count/full/empty and next-head lookahead
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int EW    = ENTRY_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [EW-1:0] wdata,
    output logic          full,
    output logic          empty,
    output logic          head_load,
    output logic [EW-1:0] head_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rptr_nxt;
    logic [AW:0]   count, count_nxt;

    // next occupancy, next read pointer and the entry that will sit at the head after this edge
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
        rptr_nxt  = pop ? rptr + 1'b1 : rptr;
        head_load = (count_nxt != '0);
        // a write landing on the new head slot is not in mem yet, so forward it
        head_data = (push && (wptr == rptr_nxt)) ? wdata : mem[rptr_nxt];
    end

    // entry storage; contents need no reset since occupancy says what is live
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // pointers, occupancy and registered full/empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            rptr  <= rptr_nxt;
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end
endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU writeback stage with flag formation and sticky debug status
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    alu_result_stage_if.slave bus,
    input  logic              clear_sticky,
    output logic              sticky_ovf,
    output logic              sticky_carry,
    output logic [CNT_W-1:0]  ovf_count
);
    localparam int EW = entry_w(TAG_W);

    logic             push, pop, full, empty;
    logic             is_arith, ev_ovf, ev_carry;
    logic [3:0]       flags_in;
    logic [EW-1:0]    wdata, head_data;
    logic             head_load;

    logic [31:0]      out_result_q;
    logic [3:0]       out_flags_q;
    logic [2:0]       out_command_q;
    logic [TAG_W-1:0] out_tag_q;

    assign push = bus.in_valid && !full;
    assign pop  = !empty && bus.out_ready;

    assign bus.in_ready    = !full;
    assign bus.out_valid   = !empty;
    assign bus.out_result  = out_result_q;
    assign bus.out_flags   = out_flags_q;
    assign bus.out_command = out_command_q;
    assign bus.out_tag     = out_tag_q;

    // flags of the incoming op; carry/overflow only mean something for ADD/SUB, SLT is never negative
    always_comb begin
        is_arith             = (bus.in_command == ALU_ADD) || (bus.in_command == ALU_SUB);
        flags_in             = '0;
        flags_in[FLAG_OVF]   = bus.in_overflow & is_arith;
        flags_in[FLAG_CARRY] = bus.in_carryout & is_arith;
        flags_in[FLAG_ZERO]  = bus.in_zero;
        flags_in[FLAG_NEG]   = bus.in_result[31] & (bus.in_command != ALU_SLT);
        // gating with push keeps X on idle inputs out of the sticky state
        ev_ovf               = push & flags_in[FLAG_OVF];
        ev_carry             = push & flags_in[FLAG_CARRY];
        wdata                = {bus.in_result, flags_in, bus.in_command, bus.in_tag};
    end

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .wdata     (wdata),
        .full      (full),
        .empty     (empty),
        .head_load (head_load),
        .head_data (head_data)
    );

    // output registers track the head; they hold their last value once the queue drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_result_q  <= '0;
            out_flags_q   <= '0;
            out_command_q <= '0;
            out_tag_q     <= '0;
        end else if (head_load) begin
            {out_result_q, out_flags_q, out_command_q, out_tag_q} <= head_data;
        end
    end

    // sticky bits and saturating overflow counter; a set event in the clear cycle wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_ovf   <= 1'b0;
            sticky_carry <= 1'b0;
            ovf_count    <= '0;
        end else if (clear_sticky) begin
            sticky_ovf   <= ev_ovf;
            sticky_carry <= ev_carry;
            ovf_count    <= {{(CNT_W-1){1'b0}}, ev_ovf};
        end else begin
            sticky_ovf   <= sticky_ovf | ev_ovf;
            sticky_carry <= sticky_carry | ev_carry;
            if (ev_ovf && (ovf_count != '1)) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end
    end
endmodule
